// File: rtl/hidden_readout_mac.sv
// Time-shared MAC readout: captures one hidden activation vector, then computes N_OUT
// saturated neuron outputs using weights and biases from external synchronous ROMs.
module hidden_readout_mac #(
    parameter int N_IN  = 128,
    parameter int N_OUT = 4,
    parameter int DW    = 9,
    parameter int ACC_W = 30,
    parameter int SHIFT = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_IN*DW-1:0]               in_data,
    output logic                             w_rd_en,
    output logic [$clog2(N_IN*N_OUT)-1:0]    w_addr,
    input  logic signed [DW-1:0]             w_rd_data,
    output logic                             b_rd_en,
    output logic [$clog2(N_OUT)-1:0]         b_addr,
    input  logic signed [DW-1:0]             b_rd_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [DW-1:0]             out_data,
    output logic [$clog2(N_OUT)-1:0]         out_idx
);

    localparam int AW = $clog2(N_IN*N_OUT);
    localparam int BW = $clog2(N_OUT);
    localparam int KW = $clog2(N_IN);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DW-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, BIAS, EMIT} state_t;

    state_t                    state;
    logic [N_IN*DW-1:0]        x_q;
    logic [KW-1:0]             rk;     // element index being read this cycle
    logic [KW-1:0]             mk;     // element index whose weight is on w_rd_data
    logic                      w_vld;
    logic [BW-1:0]             neuron;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DW-1:0]      x_cur;
    logic signed [2*DW-1:0]    prod;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DW-1:0]      sat;

    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    always_comb begin
        x_cur   = $signed(x_q[int'(mk)*DW +: DW]);
        prod    = x_cur * w_rd_data;
        sum     = acc + ACC_W'(b_rd_data);
        shifted = sum >>> SHIFT;
        if (shifted > SAT_MAX)
            sat = SAT_MAX[DW-1:0];
        else if (shifted < SAT_MIN)
            sat = SAT_MIN[DW-1:0];
        else
            sat = shifted[DW-1:0];
        in_ready = (state == IDLE) && !rst;
    end

    // NOTE: the activation store is plain datapath storage and is deliberately not reset;
    // it is only ever read after a fresh capture.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            x_q <= in_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            w_rd_en   <= 1'b0;
            b_rd_en   <= 1'b0;
            w_addr    <= '0;
            b_addr    <= '0;
            acc       <= '0;
            neuron    <= '0;
            rk        <= '0;
            mk        <= '0;
            w_vld     <= 1'b0;
        end else begin
            w_vld <= w_rd_en;
            mk    <= rk;
            if (w_vld)
                acc <= acc + ACC_W'(prod);

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neuron  <= '0;
                        rk      <= '0;
                        acc     <= '0;
                        w_rd_en <= 1'b1;
                        w_addr  <= '0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    if (rk == KW'(N_IN-1)) begin
                        w_rd_en <= 1'b0;
                        b_rd_en <= 1'b1;
                        b_addr  <= neuron;
                        state   <= DRAIN;
                    end else begin
                        rk     <= rk + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    b_rd_en <= 1'b0;
                    state   <= BIAS;
                end
                BIAS: begin
                    out_data  <= sat;
                    out_idx   <= neuron;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (neuron == BW'(N_OUT-1)) begin
                            state <= IDLE;
                        end else begin
                            neuron  <= neuron + 1'b1;
                            rk      <= '0;
                            acc     <= '0;
                            w_rd_en <= 1'b1;
                            w_addr  <= AW'((int'(neuron) + 1) * N_IN);
                            state   <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_readout_mac.sv
// Directed bench for hidden_readout_mac: ROM models, address monitor and hand-computed results.
module tb_hidden_readout_mac;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [128*9-1:0]    in_data;
    logic                w_rd_en;
    logic [8:0]          w_addr;
    logic signed [8:0]   w_rd_data;
    logic                b_rd_en;
    logic [1:0]          b_addr;
    logic signed [8:0]   b_rd_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [8:0]   out_data;
    logic [1:0]          out_idx;

    logic signed [8:0]   w_rom [512];
    logic signed [8:0]   b_rom [4];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int addr_err = 0;
    int both_err = 0;
    int acc_cnt = 0;

    hidden_readout_mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_rd_data (w_rd_data),
        .b_rd_en   (b_rd_en),
        .b_addr    (b_addr),
        .b_rd_data (b_rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_rd_en) w_rd_data <= w_rom[w_addr];
        if (b_rd_en) b_rd_data <= b_rom[b_addr];
    end

    // Weight addresses must run 0,1,2,... across all neurons of one vector.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            rd_cnt = 0;
        end else begin
            if (in_valid && in_ready) begin
                acc_cnt = acc_cnt + 1;
                rd_cnt  = 0;
            end
            if (w_rd_en) begin
                if (w_addr !== 9'(rd_cnt)) addr_err = addr_err + 1;
                rd_cnt = rd_cnt + 1;
            end
            if (w_rd_en && b_rd_en) both_err = both_err + 1;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        n_cmp = n_cmp + 1;
        assert (obs === exp_v) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_x_alt(input int xe, input int xo);
        for (int k = 0; k < 128; k++)
            in_data[k*9 +: 9] = (k % 2 == 0) ? 9'(xe) : 9'(xo);
    endtask

    task automatic load_w(input int n, input int we, input int wo);
        for (int k = 0; k < 128; k++)
            w_rom[n*128 + k] = (k % 2 == 0) ? 9'(we) : 9'(wo);
    endtask

    task automatic load_b(input int b0, input int b1, input int b2, input int b3);
        b_rom[0] = 9'(b0);
        b_rom[1] = 9'(b1);
        b_rom[2] = 9'(b2);
        b_rom[3] = 9'(b3);
    endtask

    // Caller is positioned at a negedge. One full vector with optional EMIT stalls.
    task automatic run_vec(input string name, input int stall, input bit hold,
                           input int e0, input int e1, input int e2, input int e3);
        int  exp_r [4];
        int  t_ref;
        bit  seen;
        exp_r     = '{e0, e1, e2, e3};
        acc_cnt   = 0;
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_accept"}, 32'(seen), 1);
        t_ref = cyc;
        @(negedge clk);
        in_data = ~in_data;
        if (!hold) in_valid = 1'b0;
        check({name, "_in_ready_busy"}, 32'(in_ready), 0);
        for (int n = 0; n < 4; n++) begin
            seen = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check({name, "_valid_seen"}, 32'(seen), 1);
            check({name, "_latency"}, cyc - t_ref, 131);
            for (int s = 0; s < stall; s++) begin
                check({name, "_stall_data"}, out_data, exp_r[n]);
                check({name, "_stall_idx"}, 32'(out_idx), n);
                check({name, "_stall_valid"}, 32'(out_valid), 1);
                check({name, "_stall_w_rd_en"}, 32'(w_rd_en), 0);
                check({name, "_stall_in_ready"}, 32'(in_ready), 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            check({name, "_data"}, out_data, exp_r[n]);
            check({name, "_idx"}, 32'(out_idx), n);
            if (n == 3) in_valid = 1'b0;
            t_ref = cyc;
            @(negedge clk);
            if (stall > 0) out_ready = 1'b0;
            check({name, "_valid_drop"}, 32'(out_valid), 0);
        end
        check({name, "_back_idle"}, 32'(in_ready), 1);
        check({name, "_accepts"}, acc_cnt, 1);
        check({name, "_reads"}, rd_cnt, 512);
        check({name, "_addr_seq"}, addr_err, 0);
        check({name, "_rom_overlap"}, both_err, 0);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        load_b(0, 0, 0, 0);
        for (int n = 0; n < 4; n++) load_w(n, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_w_rd_en", 32'(w_rd_en), 0);
        check("rst_b_rd_en", 32'(b_rd_en), 0);
        check("rst_w_addr", 32'(w_addr), 0);
        check("rst_b_addr", 32'(b_addr), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        // 16*16*128 = 32768, >>>9 = 64
        set_x_alt(16, 16);
        for (int n = 0; n < 4; n++) load_w(n, 16, 16);
        run_vec("pos", 0, 1'b0, 64, 64, 64, 64);

        // -32768 + 100 = -32668, >>>9 = -64
        for (int n = 0; n < 4; n++) load_w(n, -16, -16);
        load_b(0, 0, 100, 0);
        set_x_alt(16, 16);
        run_vec("neg_bias", 0, 1'b0, -64, -64, -64, -64);

        load_b(0, 0, 0, 0);
        set_x_alt(255, 255);
        for (int n = 0; n < 4; n++) load_w(n, 255, 255);
        run_vec("sat_hi", 0, 1'b0, 255, 255, 255, 255);

        set_x_alt(255, 255);
        for (int n = 0; n < 4; n++) load_w(n, -256, -256);
        run_vec("sat_lo", 0, 1'b0, -256, -256, -256, -256);

        // x=20: weights 20,-20,4,40 -> 100,-100,20,200 (200 fits in 9 bits signed? no: saturates to 255? 200<255)
        set_x_alt(20, 20);
        load_w(0, 20, 20);
        load_w(1, -20, -20);
        load_w(2, 4, 4);
        load_w(3, 40, 40);
        run_vec("stall", 10, 1'b0, 100, -100, 20, 200);

        // Alternating x (10,-6) against alternating w (8,-8): 64*80 + 64*48 = 8192 -> 16
        set_x_alt(10, -6);
        for (int n = 0; n < 4; n++) load_w(n, 8, -8);
        run_vec("hold_alt", 0, 1'b1, 16, 16, 16, 16);

        // Abort in the middle of neuron 1, then a fresh vector.
        set_x_alt(16, 16);
        for (int n = 0; n < 4; n++) load_w(n, 16, 16);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_accept", 32'(seen), 1);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_first_valid", 32'(seen), 1);
        check("abort_first_data", out_data, 64);
        @(negedge clk);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready_rst", 32'(in_ready), 0);
        check("abort_w_rd_en", 32'(w_rd_en), 0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        set_x_alt(-16, -16);
        run_vec("after_abort", 0, 1'b0, -64, -64, -64, -64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
